// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
//   Memory-access controller for a banked SRAM array of NBANK banks, each
//   2^WORD_AW x DATA_W. It arbitrates between a host port and a BIST port,
//   decodes the host address into a one-hot (active-low) bank select plus a
//   word address, and drives MEM_CE from a falling-edge delay chain. Read data
//   comes back on ODATA with a one-cycle RDATA_VLD pulse. An access that is in
//   flight when BIST_EN rises is completed before BIST takes the array.
//
// Optional feature macro: MEMCTRL_OOR_CHK_EN
//   Defined   : a host request whose bank index is >= NBANK is rejected and
//               ERR_OOR pulses for one cycle.
//   Undefined : no ERR_OOR port; such a request runs a normal window with no
//               bank selected, and a read returns zero.
//
// Ports
//   CLK, RSTN            clock, asynchronous active-low reset
//   ADDR, CE, CSB, WEB,  host request: address (bank index in the upper
//   OEB, IDATA           BANK_AW bits), strobe, select, write/read, output
//                        enable and write data
//   ODATA, RDATA_VLD     host read data and its valid pulse
//   BUSY                 controller is not idle
//   BIST_EN, BIST_MEM_*  BIST ownership and BIST-side array controls
//   MEM_*                array controls; MEM_ODATA is the concatenation of
//                        all bank outputs, bank b at [b*DATA_W +: DATA_W]
//   ERR_OOR              out-of-range pulse (only with MEMCTRL_OOR_CHK_EN)
// -----------------------------------------------------------------------------
module mem_access_ctrl #(
    parameter int DATA_W  = 8,
    parameter int WORD_AW = 10,
    parameter int NBANK   = 64,
    parameter int BANK_AW = 6,
    parameter int CE_DLY  = 2,
    parameter int RD_LAT  = 1
) (
    input  logic                      CLK,
    input  logic                      RSTN,
    input  logic [BANK_AW+WORD_AW-1:0] ADDR,
    input  logic                      CE,
    input  logic                      CSB,
    input  logic                      WEB,
    input  logic                      OEB,
    input  logic [DATA_W-1:0]         IDATA,
    output logic [DATA_W-1:0]         ODATA,
    output logic                      RDATA_VLD,
    output logic                      BUSY,
    input  logic                      BIST_EN,
    input  logic [WORD_AW-1:0]        BIST_MEM_ADDR,
    input  logic                      BIST_MEM_CE,
    input  logic                      BIST_MEM_WEB,
    input  logic [NBANK-1:0]          BIST_MEM_OEB,
    input  logic [NBANK-1:0]          BIST_MEM_CSB,
    input  logic [DATA_W-1:0]         BIST_MEM_IDATA,
    output logic [WORD_AW-1:0]        MEM_ADDR,
    output logic                      MEM_CE,
    output logic                      MEM_WEB,
    output logic [NBANK-1:0]          MEM_OEB,
    output logic [NBANK-1:0]          MEM_CSB,
    output logic [DATA_W-1:0]         MEM_IDATA,
    input  logic [NBANK*DATA_W-1:0]   MEM_ODATA
`ifdef MEMCTRL_OOR_CHK_EN
    ,
    output logic                      ERR_OOR
`endif
);

    // Access window: CE delay plus memory read latency, in cycles.
    localparam int WIN   = CE_DLY + RD_LAT;
    localparam int CNT_W = $clog2(WIN + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DRAIN  = 2'd2,
        S_BIST   = 2'd3
    } state_t;

    // Active-low one-hot bank select; an index with no bank selects nothing.
    function automatic logic [NBANK-1:0] bank_sel_n(input logic [BANK_AW-1:0] b);
        logic [NBANK-1:0] v;
        v = '1;
        for (int i = 0; i < NBANK; i++) begin
            if (b == BANK_AW'(i)) begin
                v[i] = 1'b0;
            end else begin
                v[i] = v[i];
            end
        end
        return v;
    endfunction

    // Read data of one bank; zero when the index has no bank behind it.
    function automatic logic [DATA_W-1:0] bank_rdata(
        input logic [NBANK*DATA_W-1:0] bus,
        input logic [BANK_AW-1:0]      b
    );
        logic [DATA_W-1:0] v;
        v = '0;
        for (int i = 0; i < NBANK; i++) begin
            if (b == BANK_AW'(i)) begin
                v = bus[i*DATA_W +: DATA_W];
            end else begin
                v = v;
            end
        end
        return v;
    endfunction

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BANK_AW-1:0]  bank_q, bank_d;
    logic                rd_q, rd_d;
    logic                ce_req_q, ce_req_d;
    logic [CE_DLY-1:0]   ce_chain_q, ce_chain_d;
    logic [WORD_AW-1:0]  mem_addr_q, mem_addr_d;
    logic                mem_web_q, mem_web_d;
    logic [NBANK-1:0]    mem_oeb_q, mem_oeb_d;
    logic [NBANK-1:0]    mem_csb_q, mem_csb_d;
    logic [DATA_W-1:0]   mem_idata_q, mem_idata_d;
    logic [DATA_W-1:0]   odata_q, odata_d;
    logic                vld_q, vld_d;
    logic                busy_q, busy_d;

    logic [BANK_AW-1:0]  bank_s;
    logic                req_s;
    logic                accept_s;

    assign bank_s = ADDR[BANK_AW+WORD_AW-1 -: BANK_AW];
    // A read without output enable is not a request at all.
    assign req_s  = CE & ~CSB & (~WEB | ~OEB);

`ifdef MEMCTRL_OOR_CHK_EN
    logic                oor_s;
    logic                err_oor_q, err_oor_d;
    assign oor_s    = ({{(32-BANK_AW){1'b0}}, bank_s} >= 32'(NBANK));
    assign accept_s = req_s & ~oor_s;
    assign err_oor_d = (state_q == S_IDLE) & ~BIST_EN & req_s & oor_s;
    assign ERR_OOR  = err_oor_q;
`else
    assign accept_s = req_s;
`endif

    // Next-state and next-output computation for the controller.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bank_d      = bank_q;
        rd_d        = rd_q;
        ce_req_d    = 1'b0;
        mem_addr_d  = '0;
        mem_web_d   = 1'b1;
        mem_oeb_d   = '1;
        mem_csb_d   = '1;
        mem_idata_d = '0;
        odata_d     = odata_q;
        vld_d       = 1'b0;
        busy_d      = busy_q;
        case (state_q)
            S_IDLE: begin
                if (BIST_EN) begin
                    state_d = S_BIST;
                    busy_d  = 1'b1;
                end else if (accept_s) begin
                    state_d     = S_ACCESS;
                    cnt_d       = '0;
                    bank_d      = bank_s;
                    rd_d        = WEB;
                    ce_req_d    = 1'b1;
                    mem_addr_d  = ADDR[WORD_AW-1:0];
                    mem_web_d   = WEB;
                    mem_csb_d   = bank_sel_n(bank_s);
                    mem_oeb_d   = WEB ? bank_sel_n(bank_s) : '1;
                    mem_idata_d = IDATA;
                    busy_d      = 1'b1;
                end else begin
                    busy_d = 1'b0;
                end
            end
            S_ACCESS, S_DRAIN: begin
                if (cnt_q == CNT_W'(WIN - 1)) begin
                    // End of window: return data, release the array.
                    if (rd_q) begin
                        odata_d = bank_rdata(MEM_ODATA, bank_q);
                        vld_d   = 1'b1;
                    end else begin
                        odata_d = odata_q;
                    end
                    if ((state_q == S_DRAIN) || BIST_EN) begin
                        state_d = S_BIST;
                        busy_d  = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                    end
                end else begin
                    cnt_d       = cnt_q + CNT_W'(1);
                    mem_addr_d  = mem_addr_q;
                    mem_web_d   = mem_web_q;
                    mem_oeb_d   = mem_oeb_q;
                    mem_csb_d   = mem_csb_q;
                    mem_idata_d = mem_idata_q;
                    if (BIST_EN) begin
                        state_d = S_DRAIN;
                    end else begin
                        state_d = state_q;
                    end
                end
            end
            S_BIST: begin
                if (BIST_EN) begin
                    mem_addr_d  = BIST_MEM_ADDR;
                    mem_web_d   = BIST_MEM_WEB;
                    mem_oeb_d   = BIST_MEM_OEB;
                    mem_csb_d   = BIST_MEM_CSB;
                    mem_idata_d = BIST_MEM_IDATA;
                    ce_req_d    = BIST_MEM_CE;
                    busy_d      = 1'b1;
                end else begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Shift of the falling-edge CE delay chain.
    always_comb begin
        ce_chain_d    = ce_chain_q << 1;
        ce_chain_d[0] = ce_req_q;
    end

    // Controller state and registered outputs on the rising edge.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bank_q      <= '0;
            rd_q        <= 1'b0;
            ce_req_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_web_q   <= 1'b1;
            mem_oeb_q   <= '1;
            mem_csb_q   <= '1;
            mem_idata_q <= '0;
            odata_q     <= '0;
            vld_q       <= 1'b0;
            busy_q      <= 1'b0;
`ifdef MEMCTRL_OOR_CHK_EN
            err_oor_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bank_q      <= bank_d;
            rd_q        <= rd_d;
            ce_req_q    <= ce_req_d;
            mem_addr_q  <= mem_addr_d;
            mem_web_q   <= mem_web_d;
            mem_oeb_q   <= mem_oeb_d;
            mem_csb_q   <= mem_csb_d;
            mem_idata_q <= mem_idata_d;
            odata_q     <= odata_d;
            vld_q       <= vld_d;
            busy_q      <= busy_d;
`ifdef MEMCTRL_OOR_CHK_EN
            err_oor_q   <= err_oor_d;
`endif
        end
    end

    // Falling-edge chain that places MEM_CE half a cycle off the rising edge.
    always_ff @(negedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            ce_chain_q <= '0;
        end else begin
            ce_chain_q <= ce_chain_d;
        end
    end

    assign MEM_CE    = ce_chain_q[CE_DLY-1];
    assign MEM_ADDR  = mem_addr_q;
    assign MEM_WEB   = mem_web_q;
    assign MEM_OEB   = mem_oeb_q;
    assign MEM_CSB   = mem_csb_q;
    assign MEM_IDATA = mem_idata_q;
    assign ODATA     = odata_q;
    assign RDATA_VLD = vld_q;
    assign BUSY      = busy_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_access_ctrl
//   Directed bench for mem_access_ctrl built with NBANK = 48 so that bank
//   index 50 is out of range. Read responses are queued when a read is issued
//   and checked by a monitor whenever RDATA_VLD is seen; array-side timing is
//   checked half-cycle by half-cycle against hand-derived tables.
// -----------------------------------------------------------------------------
module tb_mem_access_ctrl;

    localparam int DW  = 8;
    localparam int WA  = 10;
    localparam int NB  = 48;
    localparam int BA  = 6;

    localparam logic [NB-1:0] ALL1   = '1;
    localparam logic [NB-1:0] CSB_B1 = ~48'h0000_0000_0002;
    localparam logic [15:0]   A_B1W5 = 16'h0405;

    logic              CLK;
    logic              RSTN;
    logic [BA+WA-1:0]  ADDR;
    logic              CE, CSB, WEB, OEB;
    logic [DW-1:0]     IDATA;
    logic [DW-1:0]     ODATA;
    logic              RDATA_VLD, BUSY;
    logic              BIST_EN;
    logic [WA-1:0]     BIST_MEM_ADDR;
    logic              BIST_MEM_CE, BIST_MEM_WEB;
    logic [NB-1:0]     BIST_MEM_OEB, BIST_MEM_CSB;
    logic [DW-1:0]     BIST_MEM_IDATA;
    logic [WA-1:0]     MEM_ADDR;
    logic              MEM_CE, MEM_WEB;
    logic [NB-1:0]     MEM_OEB, MEM_CSB;
    logic [DW-1:0]     MEM_IDATA;
    logic [NB*DW-1:0]  MEM_ODATA;
`ifdef MEMCTRL_OOR_CHK_EN
    logic              ERR_OOR;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    logic [DW-1:0] exp_q[$];

    mem_access_ctrl #(
        .DATA_W(DW), .WORD_AW(WA), .NBANK(NB), .BANK_AW(BA), .CE_DLY(2), .RD_LAT(1)
    ) dut (
        .CLK(CLK), .RSTN(RSTN),
        .ADDR(ADDR), .CE(CE), .CSB(CSB), .WEB(WEB), .OEB(OEB), .IDATA(IDATA),
        .ODATA(ODATA), .RDATA_VLD(RDATA_VLD), .BUSY(BUSY),
        .BIST_EN(BIST_EN), .BIST_MEM_ADDR(BIST_MEM_ADDR), .BIST_MEM_CE(BIST_MEM_CE),
        .BIST_MEM_WEB(BIST_MEM_WEB), .BIST_MEM_OEB(BIST_MEM_OEB),
        .BIST_MEM_CSB(BIST_MEM_CSB), .BIST_MEM_IDATA(BIST_MEM_IDATA),
        .MEM_ADDR(MEM_ADDR), .MEM_CE(MEM_CE), .MEM_WEB(MEM_WEB), .MEM_OEB(MEM_OEB),
        .MEM_CSB(MEM_CSB), .MEM_IDATA(MEM_IDATA), .MEM_ODATA(MEM_ODATA)
`ifdef MEMCTRL_OOR_CHK_EN
        , .ERR_OOR(ERR_OOR)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Response monitor: every RDATA_VLD pulse must match the oldest queued read.
    always @(negedge CLK) begin
        if (RDATA_VLD === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL rdata_unexpected: got RDATA_VLD=1 ODATA=%0h expected no valid", ODATA);
            end else begin
                chk("rdata", {56'd0, ODATA}, {56'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic host_idle();
        CE = 1'b0; CSB = 1'b1; WEB = 1'b1; OEB = 1'b1; ADDR = '0; IDATA = '0;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_mem_addr"},  {54'd0, MEM_ADDR}, 64'd0);
        chk({tag, "_mem_web"},   {63'd0, MEM_WEB}, 64'd1);
        chk({tag, "_mem_oeb"},   {16'd0, MEM_OEB}, {16'd0, ALL1});
        chk({tag, "_mem_csb"},   {16'd0, MEM_CSB}, {16'd0, ALL1});
        chk({tag, "_mem_idata"}, {56'd0, MEM_IDATA}, 64'd0);
        chk({tag, "_mem_ce"},    {63'd0, MEM_CE}, 64'd0);
        chk({tag, "_busy"},      {63'd0, BUSY}, 64'd0);
        chk({tag, "_vld"},       {63'd0, RDATA_VLD}, 64'd0);
    endtask

    // One host access from accept edge k to k+3, checked every half cycle.
    // A conflicting request is held on the host port during the window.
    task automatic run_access(input string tag, input logic [15:0] addr, input logic rd,
                              input logic [DW-1:0] wdata, input logic [NB-1:0] exp_csb,
                              input logic [NB-1:0] exp_oeb, input logic [DW-1:0] exp_rd);
        ADDR = addr; CE = 1'b1; CSB = 1'b0; WEB = rd; OEB = ~rd; IDATA = wdata;
        if (rd) exp_q.push_back(exp_rd);
        tick();
        ADDR = {6'd2, 10'h3FF}; WEB = 1'b0; OEB = 1'b1; IDATA = 8'hFF;
        for (int h = 0; h < 7; h++) begin
            chk({tag, "_mem_ce"},  {63'd0, MEM_CE}, {63'd0, (h == 3 || h == 4)});
            chk({tag, "_busy"},    {63'd0, BUSY}, {63'd0, (h < 6)});
            chk({tag, "_mem_csb"}, {16'd0, MEM_CSB}, {16'd0, (h < 6) ? exp_csb : ALL1});
            chk({tag, "_mem_oeb"}, {16'd0, MEM_OEB}, {16'd0, (h < 6) ? exp_oeb : ALL1});
            chk({tag, "_mem_web"}, {63'd0, MEM_WEB}, {63'd0, (h < 6) ? rd : 1'b1});
            chk({tag, "_mem_addr"}, {54'd0, MEM_ADDR}, {54'd0, (h < 6) ? addr[WA-1:0] : 10'd0});
            chk({tag, "_mem_idata"}, {56'd0, MEM_IDATA}, {56'd0, (h < 6) ? wdata : 8'd0});
            if (h < 6) #5;
        end
        chk({tag, "_vld_end"}, {63'd0, RDATA_VLD}, {63'd0, rd});
        host_idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        RSTN = 1'b0;
        host_idle();
        BIST_EN = 1'b0; BIST_MEM_ADDR = '0; BIST_MEM_CE = 1'b0; BIST_MEM_WEB = 1'b1;
        BIST_MEM_OEB = '1; BIST_MEM_CSB = '1; BIST_MEM_IDATA = '0;
        for (int b = 0; b < NB; b++) MEM_ODATA[b*DW +: DW] = 8'(8'h30 + b);
        MEM_ODATA[1*DW +: DW] = 8'hA5;

        #12;
        chk_idle_outputs("reset");
        chk("reset_odata", {56'd0, ODATA}, 64'd0);
        RSTN = 1'b1;

        // Write bank 1 word 5, then read it back.
        run_access("wr", A_B1W5, 1'b0, 8'hA5, CSB_B1, ALL1, 8'h00);
        chk("wr_odata_held", {56'd0, ODATA}, 64'd0);
        run_access("rd", A_B1W5, 1'b1, 8'h00, CSB_B1, CSB_B1, 8'hA5);
        tick();
        chk("rd_odata_held", {56'd0, ODATA}, 64'hA5);

        // Read without output enable is ignored.
        ADDR = A_B1W5; CE = 1'b1; CSB = 1'b0; WEB = 1'b1; OEB = 1'b1;
        tick();
        host_idle();
        chk("noop_busy", {63'd0, BUSY}, 64'd0);
        chk("noop_csb", {16'd0, MEM_CSB}, {16'd0, ALL1});

        // BIST_EN rises during a read: read drains, then pass-through.
        MEM_ODATA[1*DW +: DW] = 8'h5A;
        ADDR = A_B1W5; CE = 1'b1; CSB = 1'b0; WEB = 1'b1; OEB = 1'b0;
        exp_q.push_back(8'h5A);
        tick();                                     // edge 0
        host_idle();
        BIST_EN = 1'b1; BIST_MEM_ADDR = 10'h123; BIST_MEM_WEB = 1'b0;
        BIST_MEM_CSB = 48'hFFFF_FFFF_FF0F; BIST_MEM_OEB = 48'hFFFF_0FFF_FFFF;
        BIST_MEM_IDATA = 8'h3C;
        tick();                                     // edge 1
        chk("drain_csb1", {16'd0, MEM_CSB}, {16'd0, CSB_B1});
        chk("drain_busy1", {63'd0, BUSY}, 64'd1);
        tick();                                     // edge 2
        tick();                                     // edge 3
        chk("drain_vld", {63'd0, RDATA_VLD}, 64'd1);
        chk("drain_csb3", {16'd0, MEM_CSB}, {16'd0, ALL1});
        chk("drain_addr3", {54'd0, MEM_ADDR}, 64'd0);
        chk("drain_busy3", {63'd0, BUSY}, 64'd1);
        tick();                                     // edge 4
        chk("bist_addr4", {54'd0, MEM_ADDR}, 64'h123);
        chk("bist_csb4", {16'd0, MEM_CSB}, {16'd0, 48'hFFFF_FFFF_FF0F});
        chk("bist_oeb4", {16'd0, MEM_OEB}, {16'd0, 48'hFFFF_0FFF_FFFF});
        chk("bist_web4", {63'd0, MEM_WEB}, 64'd0);
        chk("bist_idata4", {56'd0, MEM_IDATA}, 64'h3C);
        BIST_MEM_ADDR = 10'h0AB;
        #2;
        chk("bist_addr_lag", {54'd0, MEM_ADDR}, 64'h123);
        tick();                                     // edge 5
        chk("bist_addr5", {54'd0, MEM_ADDR}, 64'h0AB);

        // One-cycle BIST_MEM_CE sampled at edge n = 6.
        BIST_MEM_CE = 1'b1;
        tick();
        BIST_MEM_CE = 1'b0;
        for (int h = 0; h < 6; h++) begin
            chk("bist_mem_ce", {63'd0, MEM_CE}, {63'd0, (h == 3 || h == 4)});
            if (h < 5) #5;
        end
        chk("bist_csb_before_exit", {16'd0, MEM_CSB}, {16'd0, 48'hFFFF_FFFF_FF0F});
        BIST_EN = 1'b0;
        tick();
        chk("bist_exit_csb", {16'd0, MEM_CSB}, {16'd0, ALL1});
        chk("bist_exit_busy", {63'd0, BUSY}, 64'd0);
        #5;
        chk("bist_exit_ce", {63'd0, MEM_CE}, 64'd0);
        tick();

        // Bank index 50 does not exist with 48 banks.
`ifdef MEMCTRL_OOR_CHK_EN
        ADDR = {6'd50, 10'd7}; CE = 1'b1; CSB = 1'b0; WEB = 1'b1; OEB = 1'b0;
        tick();
        host_idle();
        chk("oor_err", {63'd0, ERR_OOR}, 64'd1);
        chk("oor_busy", {63'd0, BUSY}, 64'd0);
        chk("oor_csb", {16'd0, MEM_CSB}, {16'd0, ALL1});
        #5;
        chk("oor_ce", {63'd0, MEM_CE}, 64'd0);
        tick();
        chk("oor_err_end", {63'd0, ERR_OOR}, 64'd0);
        #5;
        chk("oor_ce2", {63'd0, MEM_CE}, 64'd0);
        tick();
`else
        run_access("oor", {6'd50, 10'd7}, 1'b1, 8'h00, ALL1, ALL1, 8'h00);
        tick();
        chk("oor_odata", {56'd0, ODATA}, 64'd0);
`endif

        // Reset in the middle of a write window.
        ADDR = A_B1W5; CE = 1'b1; CSB = 1'b0; WEB = 1'b0; OEB = 1'b1; IDATA = 8'h77;
        tick();                                     // edge 0
        host_idle();
        tick();                                     // edge 1
        tick();                                     // edge 2
        chk("rst_pre_ce", {63'd0, MEM_CE}, 64'd1);
        chk("rst_pre_busy", {63'd0, BUSY}, 64'd1);
        RSTN = 1'b0;
        #1;
        chk_idle_outputs("rst_mid");
        chk("rst_mid_odata", {56'd0, ODATA}, 64'd0);
        tick();
        chk("rst_hold_busy", {63'd0, BUSY}, 64'd0);
        #2;
        RSTN = 1'b1;
        MEM_ODATA[1*DW +: DW] = 8'hA5;
        run_access("post_rst", A_B1W5, 1'b1, 8'h00, CSB_B1, CSB_B1, 8'hA5);

        tick();
        tick();
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Parametrised memory-access controller for a banked SRAM array (NBANK banks of 2^WORD_AW x DATA_W). It arbitrates between a functional host port and the BIST engine port, decodes host addresses into a one-hot bank select plus a word address, and generates a half-cycle-delayed MEM_CE strobe on the falling clock edge. It returns read data with a valid pulse and drains any in-flight access before handing the array to BIST.

Parameters:
DATA_W, 8, data width per bank
WORD_AW, 10, word address width within a bank
NBANK, 64, number of banks
BANK_AW, 6, bank index width; must satisfy 2^BANK_AW >= NBANK
CE_DLY, 2, number of falling-edge stages in the MEM_CE delay chain; must be >= 1
RD_LAT, 1, memory read latency in cycles after MEM_CE

Ports:
CLK  in  1  clock
RSTN  in  1  asynchronous active-low reset
ADDR  in  BANK_AW+WORD_AW  host address; the upper BANK_AW bits are the bank index
CE  in  1  host request strobe
CSB  in  1  host chip select, active low
WEB  in  1  0 = write, 1 = read
OEB  in  1  read output enable, active low
IDATA  in  DATA_W  host write data
ODATA  out  DATA_W  host read data
RDATA_VLD  out  1  read data valid, 1-cycle pulse
BUSY  out  1  high when the controller is not in IDLE
BIST_EN  in  1  BIST owns the array
BIST_MEM_ADDR  in  WORD_AW  BIST word address
BIST_MEM_CE  in  1  BIST memory enable
BIST_MEM_WEB  in  1  BIST write enable, active low
BIST_MEM_OEB  in  NBANK  BIST per-bank output enable, active low
BIST_MEM_CSB  in  NBANK  BIST per-bank chip select, active low
BIST_MEM_IDATA  in  DATA_W  BIST write data
MEM_ADDR  out  WORD_AW  array word address
MEM_CE  out  1  array enable, driven from the falling-edge chain
MEM_WEB  out  1  array write enable, active low
MEM_OEB  out  NBANK  per-bank output enable, active low
MEM_CSB  out  NBANK  per-bank chip select, active low
MEM_IDATA  out  DATA_W  array write data
MEM_ODATA  in  NBANK*DATA_W  concatenated bank outputs; bank b occupies [b*DATA_W +: DATA_W]
ERR_OOR  out  1  out-of-range pulse; present only with the macro

Behaviour:
- Reset (RSTN low, async) drives these values:
  - MEM_ADDR = 0, MEM_WEB = 1, MEM_OEB = all 1, MEM_CSB = all 1, MEM_IDATA = 0, MEM_CE = 0.
  - ODATA = 0, RDATA_VLD = 0, BUSY = 0, ERR_OOR = 0.
  - State = IDLE; CE chain and counter cleared.
  - Reset mid-access aborts immediately with no data returned.
- Idle drive values: the reset values of the MEM_* outputs, asserted whenever not in ACCESS or BIST.
- State IDLE:
  - If BIST_EN = 1, go to BIST. BIST wins over a simultaneous request, and the request is dropped.
  - Otherwise a request is accepted at rising edge k when CE = 1 and CSB = 0. A read additionally needs OEB = 0; a read with OEB = 1 is a no-op.
  - On accept, go to ACCESS and clear the counter.
- State ACCESS (window W = CE_DLY + RD_LAT cycles):
  - From edge k, MEM_* are registered from the latched request:
    - MEM_ADDR = ADDR[WORD_AW-1:0].
    - MEM_CSB has a single 0 at the bank index.
    - MEM_OEB has a single 0 at the bank index for reads, else all 1.
    - MEM_WEB = latched WEB; MEM_IDATA = latched IDATA.
  - These values are held until edge k+W.
  - An internal ce_req is high for exactly one cycle (k to k+1).
  - ce_req passes through CE_DLY falling-edge flops. MEM_CE is high from k+CE_DLY-0.5 to k+CE_DLY+0.5.
  - At edge k+W, a read captures the MEM_ODATA slice of the latched bank into ODATA, and RDATA_VLD pulses for 1 cycle. A write returns no data.
  - At edge k+W, MEM_* return to idle values and the state returns to IDLE. The next accept is possible at edge k+W+1 at the earliest.
  - BUSY is high for cycles k to k+W.
  - Host inputs are ignored while BUSY; ODATA holds its last captured value.
- BIST_EN rising during ACCESS: enter DRAIN. DRAIN completes the window exactly as ACCESS does, then goes to BIST.
- State BIST:
  - Each cycle, MEM_ADDR, MEM_WEB, MEM_OEB, MEM_CSB and MEM_IDATA are registered from the BIST_MEM_* inputs (1-cycle latency).
  - BIST_MEM_CE feeds the CE chain.
  - BIST_EN = 0 sends the state to IDLE. The next edge drives idle values, and the CE chain loads 0 on subsequent falling edges.
  - BUSY stays high in BIST.
- Out-of-range bank index (index >= NBANK): see Optional Feature.

Optional Feature:
Macro MEMCTRL_OOR_CHK_EN.
- Defined:
  - An out-of-range request is rejected: no ACCESS, no MEM_* activity.
  - ERR_OOR pulses for 1 cycle after the accepting edge; BUSY stays low.
- Undefined:
  - There is no ERR_OOR port.
  - An out-of-range request runs the full ACCESS window with MEM_CSB and MEM_OEB all 1.
  - A read returns ODATA = 0 with RDATA_VLD.

Test Plan:
- Write at ADDR 0x0405 (bank 1, word 0x005), IDATA 0xA5, defaults:
  - MEM_CSB bit1 = 0 and MEM_WEB = 0 for edges 0 to 3.
  - MEM_CE high from 1.5 to 2.5.
  - BUSY is low after edge 3.
- Read of the same address with MEM_ODATA bank-1 slice = 0xA5:
  - ODATA = 0xA5 and RDATA_VLD = 1 for the cycle after edge 3.
  - MEM_OEB bit1 = 0 during the window.
- BIST_EN raised at edge 1 of a read:
  - The read completes, with RDATA_VLD after edge 3.
  - BIST pass-through starts at edge 4; MEM_ADDR follows BIST_MEM_ADDR one cycle later.
- In BIST, BIST_MEM_CE pulsed for one cycle at edge n:
  - MEM_CE high from n+1.5 to n+2.5.
  - Dropping BIST_EN returns MEM_CSB to all 1 on the next edge.
- NBANK = 48, ADDR bank index 50:
  - With the macro: ERR_OOR pulses and there is no MEM activity.
  - Without the macro: a 3-cycle window with all CSB = 1, and ODATA = 0 with RDATA_VLD.
- RSTN low at edge 2 of a write:
  - All outputs are at reset values immediately, and no RDATA_VLD follows.
  - An accept succeeds on the first edge after reset is released.
